// File: rtl/matbi_dma_burst_engine.sv
// rtl/matbi_dma_burst_engine.sv - AXI4 read/write burst DMA with 4 KB-safe bursts and ap_ctrl start/done
// Optional MATBI_DMA_PERF_CNT_EN adds per-channel cycle counters rdma_cycles/wdma_cycles.
module matbi_dma_burst_engine #(
  parameter int C_M_AXI_ADDR_WIDTH = 32,
  parameter int C_M_AXI_DATA_WIDTH = 64,
  parameter int C_MAX_BURST_LEN    = 16
) (
  input  logic                            ap_clk,
  input  logic                            areset,
  input  logic                            ap_start,
  output logic                            ap_idle,
  output logic                            ap_done,
  output logic                            ap_ready,
  output logic                            ap_err,
  input  logic [31:0]                     rdma_transfer_byte,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]   rdma_mem_ptr,
  input  logic [31:0]                     wdma_transfer_byte,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]   wdma_mem_ptr,
  output logic                            m_axi_arvalid,
  input  logic                            m_axi_arready,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   m_axi_araddr,
  output logic [7:0]                      m_axi_arlen,
  output logic [2:0]                      m_axi_arsize,
  output logic [1:0]                      m_axi_arburst,
  input  logic                            m_axi_rvalid,
  output logic                            m_axi_rready,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   m_axi_rdata,
  input  logic                            m_axi_rlast,
  input  logic [1:0]                      m_axi_rresp,
  output logic                            m_axi_awvalid,
  input  logic                            m_axi_awready,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic [7:0]                      m_axi_awlen,
  output logic [2:0]                      m_axi_awsize,
  output logic [1:0]                      m_axi_awburst,
  output logic                            m_axi_wvalid,
  input  logic                            m_axi_wready,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0] m_axi_wstrb,
  output logic                            m_axi_wlast,
  input  logic                            m_axi_bvalid,
  output logic                            m_axi_bready,
  input  logic [1:0]                      m_axi_bresp,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   out_r_din,
  input  logic                            out_r_full_n,
  output logic                            out_r_write,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   in_r_dout,
  input  logic                            in_r_empty_n,
  output logic                            in_r_read
`ifdef MATBI_DMA_PERF_CNT_EN
  ,
  output logic [31:0]                     rdma_cycles,
  output logic [31:0]                     wdma_cycles
`endif
);
  localparam int AW  = C_M_AXI_ADDR_WIDTH;
  localparam int BPB = C_M_AXI_DATA_WIDTH / 8;
  localparam int LG  = $clog2(BPB);

  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA, R_DONE} rd_state_e;
  typedef enum logic [2:0] {W_IDLE, W_ADDR, W_DATA, W_RESP, W_DONE} wr_state_e;

  rd_state_e     rd_state_q;
  wr_state_e     wr_state_q;
  logic          start_q, idle_q, done_q, err_q;
  logic          arvalid_q, awvalid_q, bready_q;
  logic [AW-1:0] raddr_q, waddr_q;
  logic [31:0]   rrem_q, wrem_q;
  logic [7:0]    wcnt_q;

  logic [31:0]   rd_total_d, wr_total_d, rd_beats_d, wr_beats_d;
  logic          start_edge_d, r_fire_d, w_fire_d, b_fire_d;

  // Largest burst that fits the remaining count, the beat cap and the current 4 KB page.
  function automatic logic [31:0] burst_beats(input logic [31:0] rem, input logic [11:0] page_off);
    logic [31:0] lim;
    lim = (32'd4096 - {20'd0, page_off}) >> LG;
    if (lim > 32'(C_MAX_BURST_LEN)) lim = 32'(C_MAX_BURST_LEN);
    return (rem < lim) ? rem : lim;
  endfunction

  assign start_edge_d = ap_start & ~start_q & idle_q;
  assign rd_total_d   = rdma_transfer_byte >> LG;
  assign wr_total_d   = wdma_transfer_byte >> LG;
  assign rd_beats_d   = burst_beats(rrem_q, raddr_q[11:0]);
  assign wr_beats_d   = burst_beats(wrem_q, waddr_q[11:0]);

  assign m_axi_rready = (rd_state_q == R_DATA) & out_r_full_n;
  assign r_fire_d     = m_axi_rvalid & m_axi_rready;
  assign out_r_write  = r_fire_d;
  assign out_r_din    = m_axi_rdata;

  assign m_axi_wvalid = (wr_state_q == W_DATA) & in_r_empty_n;
  assign w_fire_d     = m_axi_wvalid & m_axi_wready;
  assign in_r_read    = w_fire_d;
  assign m_axi_wdata  = in_r_dout;
  assign m_axi_wstrb  = '1;
  assign m_axi_wlast  = (wr_state_q == W_DATA) && (wcnt_q == 8'd0);
  assign b_fire_d     = m_axi_bvalid & bready_q;
  assign m_axi_bready = bready_q;

  assign m_axi_arvalid = arvalid_q;
  assign m_axi_araddr  = raddr_q;
  assign m_axi_arlen   = 8'(rd_beats_d - 32'd1);
  assign m_axi_arsize  = 3'(LG);
  assign m_axi_arburst = 2'b01;
  assign m_axi_awvalid = awvalid_q;
  assign m_axi_awaddr  = waddr_q;
  assign m_axi_awlen   = 8'(wr_beats_d - 32'd1);
  assign m_axi_awsize  = 3'(LG);
  assign m_axi_awburst = 2'b01;

  assign ap_idle  = idle_q;
  assign ap_done  = done_q;
  assign ap_ready = done_q;
  assign ap_err   = err_q;

  always_ff @(posedge ap_clk or posedge areset) begin
    if (areset) begin
      rd_state_q <= R_IDLE;
      wr_state_q <= W_IDLE;
      start_q    <= 1'b0;
      idle_q     <= 1'b1;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      arvalid_q  <= 1'b0;
      awvalid_q  <= 1'b0;
      bready_q   <= 1'b0;
      raddr_q    <= '0;
      waddr_q    <= '0;
      rrem_q     <= '0;
      wrem_q     <= '0;
      wcnt_q     <= '0;
    end else begin
      start_q <= ap_start;
      done_q  <= 1'b0;
      if ((r_fire_d && m_axi_rresp != 2'b00) || (b_fire_d && m_axi_bresp != 2'b00))
        err_q <= 1'b1;
      if (start_edge_d) begin
        idle_q     <= 1'b0;
        err_q      <= 1'b0;
        raddr_q    <= rdma_mem_ptr & ~AW'(BPB - 1);
        waddr_q    <= wdma_mem_ptr & ~AW'(BPB - 1);
        rrem_q     <= rd_total_d;
        wrem_q     <= wr_total_d;
        rd_state_q <= (rd_total_d == 32'd0) ? R_DONE : R_ADDR;
        wr_state_q <= (wr_total_d == 32'd0) ? W_DONE : W_ADDR;
        arvalid_q  <= (rd_total_d != 32'd0);
        awvalid_q  <= (wr_total_d != 32'd0);
      end else if (!idle_q) begin
        case (rd_state_q)
          R_ADDR: if (m_axi_arready) begin
            arvalid_q  <= 1'b0;
            rrem_q     <= rrem_q - rd_beats_d;
            raddr_q    <= raddr_q + AW'(rd_beats_d << LG);
            rd_state_q <= R_DATA;
          end
          R_DATA: if (r_fire_d && m_axi_rlast) begin
            rd_state_q <= (rrem_q != 32'd0) ? R_ADDR : R_DONE;
            arvalid_q  <= (rrem_q != 32'd0);
          end
          default: ;
        endcase
        case (wr_state_q)
          W_ADDR: if (m_axi_awready) begin
            awvalid_q  <= 1'b0;
            wrem_q     <= wrem_q - wr_beats_d;
            waddr_q    <= waddr_q + AW'(wr_beats_d << LG);
            wcnt_q     <= 8'(wr_beats_d - 32'd1);
            wr_state_q <= W_DATA;
          end
          W_DATA: if (w_fire_d) begin
            if (wcnt_q == 8'd0) begin
              bready_q   <= 1'b1;
              wr_state_q <= W_RESP;
            end else begin
              wcnt_q <= wcnt_q - 8'd1;
            end
          end
          // Only one write burst in flight: the next AW waits for this response.
          W_RESP: if (m_axi_bvalid) begin
            bready_q   <= 1'b0;
            wr_state_q <= (wrem_q != 32'd0) ? W_ADDR : W_DONE;
            awvalid_q  <= (wrem_q != 32'd0);
          end
          default: ;
        endcase
        if (rd_state_q == R_DONE && wr_state_q == W_DONE) begin
          done_q     <= 1'b1;
          idle_q     <= 1'b1;
          rd_state_q <= R_IDLE;
          wr_state_q <= W_IDLE;
        end
      end
    end
  end

`ifdef MATBI_DMA_PERF_CNT_EN
  logic [31:0] rcyc_q, wcyc_q;

  always_ff @(posedge ap_clk or posedge areset) begin
    if (areset) begin
      rcyc_q <= '0;
      wcyc_q <= '0;
    end else if (start_edge_d) begin
      rcyc_q <= '0;
      wcyc_q <= '0;
    end else if (!idle_q) begin
      if (rd_state_q != R_DONE && rcyc_q != '1) rcyc_q <= rcyc_q + 32'd1;
      if (wr_state_q != W_DONE && wcyc_q != '1) wcyc_q <= wcyc_q + 32'd1;
    end
  end

  assign rdma_cycles = rcyc_q;
  assign wdma_cycles = wcyc_q;
`endif
endmodule

// File: tb/tb_matbi_dma_burst_engine.sv
// tb/tb_matbi_dma_burst_engine.sv - scoreboard bench for matbi_dma_burst_engine with AXI slave and stream models
module tb_matbi_dma_burst_engine;
  logic        ap_clk = 1'b0;
  logic        areset;
  logic        ap_start;
  logic        ap_idle, ap_done, ap_ready, ap_err;
  logic [31:0] rdma_transfer_byte, rdma_mem_ptr, wdma_transfer_byte, wdma_mem_ptr;
  logic        m_axi_arvalid, m_axi_arready;
  logic [31:0] m_axi_araddr;
  logic [7:0]  m_axi_arlen;
  logic [2:0]  m_axi_arsize;
  logic [1:0]  m_axi_arburst;
  logic        m_axi_rvalid, m_axi_rready, m_axi_rlast;
  logic [63:0] m_axi_rdata;
  logic [1:0]  m_axi_rresp;
  logic        m_axi_awvalid, m_axi_awready;
  logic [31:0] m_axi_awaddr;
  logic [7:0]  m_axi_awlen;
  logic [2:0]  m_axi_awsize;
  logic [1:0]  m_axi_awburst;
  logic        m_axi_wvalid, m_axi_wready, m_axi_wlast;
  logic [63:0] m_axi_wdata;
  logic [7:0]  m_axi_wstrb;
  logic        m_axi_bvalid, m_axi_bready;
  logic [1:0]  m_axi_bresp;
  logic [63:0] out_r_din, in_r_dout;
  logic        out_r_full_n, out_r_write, in_r_empty_n, in_r_read;

  matbi_dma_burst_engine #(
    .C_M_AXI_ADDR_WIDTH(32), .C_M_AXI_DATA_WIDTH(64), .C_MAX_BURST_LEN(16)
  ) dut (
    .ap_clk(ap_clk), .areset(areset), .ap_start(ap_start), .ap_idle(ap_idle),
    .ap_done(ap_done), .ap_ready(ap_ready), .ap_err(ap_err),
    .rdma_transfer_byte(rdma_transfer_byte), .rdma_mem_ptr(rdma_mem_ptr),
    .wdma_transfer_byte(wdma_transfer_byte), .wdma_mem_ptr(wdma_mem_ptr),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready), .m_axi_araddr(m_axi_araddr),
    .m_axi_arlen(m_axi_arlen), .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready), .m_axi_rdata(m_axi_rdata),
    .m_axi_rlast(m_axi_rlast), .m_axi_rresp(m_axi_rresp),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready), .m_axi_awaddr(m_axi_awaddr),
    .m_axi_awlen(m_axi_awlen), .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready), .m_axi_wdata(m_axi_wdata),
    .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
    .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready), .m_axi_bresp(m_axi_bresp),
    .out_r_din(out_r_din), .out_r_full_n(out_r_full_n), .out_r_write(out_r_write),
    .in_r_dout(in_r_dout), .in_r_empty_n(in_r_empty_n), .in_r_read(in_r_read)
  );

  always #5 ap_clk = ~ap_clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [39:0] exp_ar[$];
  logic [39:0] exp_aw[$];
  logic [63:0] exp_rd[$];
  logic [64:0] exp_w[$];
  logic [63:0] src_q[$];

  bit ready_always;
  int full_mode;
  int err_burst;
  int b_idx;

  function automatic void check(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endfunction

  function automatic logic [63:0] mem_word(input logic [31:0] addr);
    return {addr ^ 32'hA5A5_0000, ~addr};
  endfunction

  // Reference model: split a transfer into 4 KB-safe bursts of at most 16 beats.
  function automatic void plan(input logic [31:0] ptr, input int bytes, input bit is_rd);
    logic [31:0] addr;
    logic [63:0] d;
    int n, b, room;
    addr = ptr & 32'hFFFF_FFF8;
    n = bytes / 8;
    while (n > 0) begin
      room = (4096 - int'(addr % 4096)) / 8;
      b = (n < 16) ? n : 16;
      if (b > room) b = room;
      if (is_rd) exp_ar.push_back({addr, 8'(b - 1)});
      else exp_aw.push_back({addr, 8'(b - 1)});
      for (int i = 0; i < b; i++) begin
        if (is_rd) exp_rd.push_back(mem_word(addr + 32'(8 * i)));
        else begin
          d = {$urandom, $urandom};
          src_q.push_back(d);
          exp_w.push_back({(i == b - 1), d});
        end
      end
      addr += 32'(8 * b);
      n -= b;
    end
  endfunction

  // AXI slave and stream endpoints: sample handshakes mid-cycle, drive new values after the edge.
  logic [31:0] r_pend_addr[$];
  logic [7:0]  r_pend_len[$];
  int r_beat, b_cnt;
  initial begin : slave
    bit arf, rf, wf, wl, bf, rdf;
    logic [31:0] ara;
    logic [7:0]  arl;
    r_beat = 0;
    b_cnt  = 0;
    forever begin
      @(negedge ap_clk);
      arf = m_axi_arvalid && m_axi_arready;
      ara = m_axi_araddr;
      arl = m_axi_arlen;
      rf  = m_axi_rvalid && m_axi_rready;
      wf  = m_axi_wvalid && m_axi_wready;
      wl  = m_axi_wlast;
      bf  = m_axi_bvalid && m_axi_bready;
      rdf = in_r_read;
      @(posedge ap_clk);
      #1;
      if (areset) begin
        r_pend_addr.delete();
        r_pend_len.delete();
        src_q.delete();
        r_beat = 0;
        b_cnt = 0;
        m_axi_rvalid = 1'b0;
        m_axi_bvalid = 1'b0;
        in_r_empty_n = 1'b0;
      end else begin
        m_axi_arready = ready_always ? 1'b1 : 1'($urandom_range(0, 1));
        m_axi_awready = ready_always ? 1'b1 : 1'($urandom_range(0, 1));
        m_axi_wready  = ready_always ? 1'b1 : 1'($urandom_range(0, 1));
        if (full_mode == 0) out_r_full_n = 1'b1;
        else if (full_mode == 1) out_r_full_n = ~out_r_full_n;
        else out_r_full_n = 1'($urandom_range(0, 1));
        if (arf) begin
          r_pend_addr.push_back(ara);
          r_pend_len.push_back(arl);
        end
        if (rf) begin
          m_axi_rvalid = 1'b0;
          if (r_beat == int'(r_pend_len[0])) begin
            void'(r_pend_addr.pop_front());
            void'(r_pend_len.pop_front());
            r_beat = 0;
          end else r_beat++;
        end
        if (!m_axi_rvalid && r_pend_addr.size() > 0 && (ready_always || $urandom_range(0, 3) != 0)) begin
          m_axi_rvalid = 1'b1;
          m_axi_rdata  = mem_word(r_pend_addr[0] + 32'(8 * r_beat));
          m_axi_rlast  = (r_beat == int'(r_pend_len[0]));
          m_axi_rresp  = 2'b00;
        end
        if (wf && wl) b_cnt++;
        if (bf) m_axi_bvalid = 1'b0;
        if (!m_axi_bvalid && b_cnt > 0 && (ready_always || $urandom_range(0, 1) != 0)) begin
          m_axi_bvalid = 1'b1;
          m_axi_bresp  = (b_idx == err_burst) ? 2'b10 : 2'b00;
          b_idx++;
          b_cnt--;
        end
        if (rdf) void'(src_q.pop_front());
        if (!in_r_empty_n || rdf) begin
          in_r_empty_n = (src_q.size() > 0) && (ready_always || $urandom_range(0, 2) != 0);
          in_r_dout    = (src_q.size() > 0) ? src_q[0] : 64'd0;
        end
      end
    end
  end

  // Monitor: pop expected items whenever the DUT completes a handshake.
  bit ar_hold, aw_hold;
  logic [39:0] ar_hold_v, aw_hold_v;
  logic [39:0] e40;
  logic [64:0] e65;
  always @(negedge ap_clk) begin
    if (areset) begin
      ar_hold = 1'b0;
      aw_hold = 1'b0;
    end else begin
      if (ar_hold) check("ar_held", 96'({m_axi_arvalid, m_axi_araddr, m_axi_arlen}), 96'({1'b1, ar_hold_v}));
      if (aw_hold) check("aw_held", 96'({m_axi_awvalid, m_axi_awaddr, m_axi_awlen}), 96'({1'b1, aw_hold_v}));
      ar_hold   = m_axi_arvalid && !m_axi_arready;
      ar_hold_v = {m_axi_araddr, m_axi_arlen};
      aw_hold   = m_axi_awvalid && !m_axi_awready;
      aw_hold_v = {m_axi_awaddr, m_axi_awlen};
      if (m_axi_arvalid && m_axi_arready) begin
        if (exp_ar.size() == 0) check("ar_unexpected", 96'({m_axi_araddr, m_axi_arlen}), 96'(0));
        else begin
          e40 = exp_ar.pop_front();
          check("ar_addr_len", 96'({m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst}), 96'({e40, 3'd3, 2'b01}));
        end
      end
      if (m_axi_awvalid && m_axi_awready) begin
        if (exp_aw.size() == 0) check("aw_unexpected", 96'({m_axi_awaddr, m_axi_awlen}), 96'(0));
        else begin
          e40 = exp_aw.pop_front();
          check("aw_addr_len", 96'({m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst}), 96'({e40, 3'd3, 2'b01}));
        end
      end
      if (m_axi_rvalid) check("rready_mirrors_full_n", 96'(m_axi_rready), 96'(out_r_full_n));
      if (out_r_write) begin
        if (exp_rd.size() == 0) check("rd_unexpected", 96'(out_r_din), 96'(0));
        else check("rd_data", 96'(out_r_din), 96'(exp_rd.pop_front()));
      end
      if (m_axi_wvalid && m_axi_wready) begin
        if (exp_w.size() == 0) check("w_unexpected", 96'(m_axi_wdata), 96'(0));
        else begin
          e65 = exp_w.pop_front();
          check("w_strb_last_data", 96'({m_axi_wstrb, m_axi_wlast, m_axi_wdata}), 96'({8'hFF, e65}));
        end
      end
    end
  end

  task automatic do_reset();
    @(posedge ap_clk);
    #1;
    areset = 1'b1;
    repeat (2) @(posedge ap_clk);
    #1;
    areset = 1'b0;
  endtask

  task automatic start_xfer(input logic [31:0] rptr, input int rbytes, input logic [31:0] wptr,
                            input int wbytes, input int fmode, input bit rdy_all, input int errb);
    exp_ar.delete(); exp_aw.delete(); exp_rd.delete(); exp_w.delete(); src_q.delete();
    plan(rptr, rbytes, 1'b1);
    plan(wptr, wbytes, 1'b0);
    full_mode = fmode;
    ready_always = rdy_all;
    err_burst = errb;
    b_idx = 0;
    @(posedge ap_clk);
    #1;
    rdma_mem_ptr = rptr;
    rdma_transfer_byte = 32'(rbytes);
    wdma_mem_ptr = wptr;
    wdma_transfer_byte = 32'(wbytes);
    ap_start = 1'b1;
    @(posedge ap_clk);
    #1;
    ap_start = 1'b0;
  endtask

  task automatic run_test(input string tag, input logic [31:0] rptr, input int rbytes, input logic [31:0] wptr,
                          input int wbytes, input int fmode, input bit rdy_all, input int errb, input int exp_lat);
    int cyc;
    bit got, exp_err;
    start_xfer(rptr, rbytes, wptr, wbytes, fmode, rdy_all, errb);
    exp_err = (errb >= 0) && (errb < exp_aw.size());
    @(negedge ap_clk);
    check({tag, "_busy_err_clear"}, 96'({ap_idle, ap_err}), 96'(2'b00));
    cyc = 1;
    got = 1'b0;
    while (!got && cyc < 5000) begin
      if (ap_done) got = 1'b1;
      else begin
        @(negedge ap_clk);
        cyc++;
      end
    end
    if (!got) begin
      check({tag, "_done_timeout"}, 96'(0), 96'(1));
      do_reset();
    end else begin
      check({tag, "_done_ready_idle_err"}, 96'({ap_ready, ap_idle, ap_err}), 96'({1'b1, 1'b1, exp_err}));
      if (exp_lat > 0) check({tag, "_done_latency"}, 96'(cyc), 96'(exp_lat));
      @(negedge ap_clk);
      check({tag, "_done_one_pulse"}, 96'(ap_done), 96'(0));
      check({tag, "_all_expected_seen"}, 96'(exp_ar.size() + exp_aw.size() + exp_rd.size() + exp_w.size()), 96'(0));
    end
  endtask

  initial begin
    logic [31:0] rp, wp;
    int rb, wb, eb;
    areset = 1'b1;
    ap_start = 1'b0;
    rdma_transfer_byte = '0; rdma_mem_ptr = '0; wdma_transfer_byte = '0; wdma_mem_ptr = '0;
    m_axi_arready = 1'b0; m_axi_awready = 1'b0; m_axi_wready = 1'b0;
    m_axi_rvalid = 1'b0; m_axi_rdata = '0; m_axi_rlast = 1'b0; m_axi_rresp = 2'b00;
    m_axi_bvalid = 1'b0; m_axi_bresp = 2'b00;
    out_r_full_n = 1'b1; in_r_dout = '0; in_r_empty_n = 1'b0;
    ready_always = 1'b1; full_mode = 0; err_burst = -1; b_idx = 0;
    repeat (3) @(posedge ap_clk);
    #1;
    areset = 1'b0;
    @(negedge ap_clk);
    check("reset_ctrl", 96'({ap_idle, ap_done, ap_ready, ap_err}), 96'(4'b1000));
    check("reset_axi", 96'({m_axi_arvalid, m_axi_awvalid, m_axi_wvalid, m_axi_rready, m_axi_bready,
                           out_r_write, in_r_read}), 96'(0));

    run_test("rd256", 32'h1000, 256, 32'h8000, 0, 0, 1'b1, -1, 0);
    run_test("wr64_4k_split", 32'h0, 0, 32'h0FE0, 64, 0, 1'b1, -1, 0);
    run_test("full_toggle", 32'h2000, 128, 32'h0, 0, 1, 1'b1, -1, 0);
    run_test("zero", 32'h0, 0, 32'h0, 0, 0, 1'b1, -1, 2);
    run_test("bresp_err", 32'h0, 0, 32'h4000, 256, 0, 1'b0, 0, 0);
    run_test("err_cleared", 32'h0108, 64, 32'h0200, 64, 2, 1'b0, -1, 0);

    start_xfer(32'h0, 512, 32'h3000, 512, 2, 1'b0, -1);
    repeat (12) @(negedge ap_clk);
    check("pre_reset_busy", 96'(ap_idle), 96'(0));
    @(posedge ap_clk);
    #1;
    areset = 1'b1;
    #1;
    check("async_reset_outputs", 96'({ap_idle, ap_done, m_axi_arvalid, m_axi_awvalid, m_axi_wvalid,
                                      m_axi_rready, m_axi_bready, out_r_write, in_r_read}), 96'(9'b1_0000_0000));
    repeat (2) @(posedge ap_clk);
    #1;
    areset = 1'b0;
    run_test("after_reset", 32'h0FC0, 200, 32'h5FF8, 136, 2, 1'b0, -1, 0);

    for (int t = 0; t < 8; t++) begin
      rp = (32'($urandom_range(0, 7)) << 12) + (32'($urandom_range(0, 511)) << 3) + 32'($urandom_range(0, 7));
      wp = (32'($urandom_range(8, 15)) << 12) + (32'($urandom_range(0, 511)) << 3);
      rb = $urandom_range(0, 70) * 8 + $urandom_range(0, 7);
      wb = $urandom_range(0, 70) * 8 + $urandom_range(0, 7);
      eb = (t % 3 == 0) ? $urandom_range(0, 2) : -1;
      run_test("rand", rp, rb, wp, wb, $urandom_range(0, 2), 1'($urandom_range(0, 1)), eb, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
